// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline with a private EX/MEM/WB destination scoreboard.
// Outputs are combinational from state + ID inputs; the scoreboard, FSM and stall counter update on each rising edge.
module pipe_hazard_ctrl #(
    parameter int REG_W   = 3,
    parameter int STCNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               id_valid_i,
    input  logic [REG_W-1:0]   id_rs_i,
    input  logic               id_rs_used_i,
    input  logic [REG_W-1:0]   id_rt_i,
    input  logic               id_rt_used_i,
    input  logic               id_wr_en_i,
    input  logic [REG_W-1:0]   id_wr_reg_i,
    input  logic               id_halt_i,
    input  logic               mem_redirect_i,
    output logic               pc_stall_o,
    output logic               id_ex_bubble_o,
    output logic               flush_if_id_o,
    output logic               flush_id_ex_o,
    output logic               flush_ex_mem_o,
    output logic               halted_o,
    output logic [STCNT_W-1:0] stall_count_o
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] r;
    } sb_t;

    state_e             state_q, state_d;
    logic [1:0]         drain_q, drain_d;
    logic               halted_q, halted_d;
    logic [STCNT_W-1:0] stall_cnt_q, stall_cnt_d;
    sb_t                sb_ex_q, sb_mem_q, sb_wb_q;
    sb_t                sb_ex_d, sb_mem_d, sb_wb_d;

    logic redirect;
    logic rs_match, rt_match, hazard;
    logic issue, stall_case;

    // Once halted the pipeline is empty, so a stray redirect has nothing to act on.
    assign redirect = mem_redirect_i && (state_q != HALTED);

    assign rs_match = (sb_ex_q.v  && (sb_ex_q.r  == id_rs_i)) ||
                      (sb_mem_q.v && (sb_mem_q.r == id_rs_i)) ||
                      (sb_wb_q.v  && (sb_wb_q.r  == id_rs_i));
    assign rt_match = (sb_ex_q.v  && (sb_ex_q.r  == id_rt_i)) ||
                      (sb_mem_q.v && (sb_mem_q.r == id_rt_i)) ||
                      (sb_wb_q.v  && (sb_wb_q.r  == id_rt_i));
    assign hazard   = id_valid_i && ((id_rs_used_i && rs_match) || (id_rt_used_i && rt_match));

    always_comb begin
        pc_stall_o     = 1'b0;
        id_ex_bubble_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        flush_ex_mem_o = 1'b0;
        stall_case     = 1'b0;
        issue          = 1'b0;
        if (!rst_ni || redirect) begin
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
        end else if (state_q != RUN) begin
            pc_stall_o     = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (hazard) begin
            pc_stall_o     = 1'b1;
            id_ex_bubble_o = 1'b1;
            stall_case     = 1'b1;
        end else begin
            issue = id_valid_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        halted_d = halted_q;
        case (state_q)
            RUN: begin
                if (issue && id_halt_i) begin
                    state_d = DRAIN;
                    drain_d = 2'd3;
                end
            end
            DRAIN: begin
                // drain_q == 3 means HALT sits in EX, still younger than a redirect in MEM.
                if (redirect && (drain_q == 2'd3)) begin
                    state_d = RUN;
                    drain_d = 2'd0;
                end else if (drain_q == 2'd1) begin
                    state_d  = HALTED;
                    drain_d  = 2'd0;
                    halted_d = 1'b1;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            HALTED:  ;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        sb_wb_d  = sb_mem_q;
        sb_mem_d = redirect ? '0 : sb_ex_q;
        sb_ex_d  = issue ? sb_t'{v: id_wr_en_i, r: id_wr_reg_i} : '0;
        stall_cnt_d = stall_cnt_q;
        if (stall_case && (stall_cnt_q != {STCNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            drain_q     <= 2'd0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            sb_ex_q     <= '0;
            sb_mem_q    <= '0;
            sb_wb_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            sb_wb_q     <= sb_wb_d;
        end
    end

    assign halted_o      = halted_q;
    assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: an age-based in-flight-writer model predicts every cycle's outputs; a monitor compares them.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt, mem_redirect;
    logic [2:0]  id_rs, id_rt, id_wr_reg;
    logic        pc_stall, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, halted;
    logic [15:0] stall_count;

    pipe_hazard_ctrl #(.REG_W(3), .STCNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(id_rs_used),
        .id_rt_i(id_rt), .id_rt_used_i(id_rt_used), .id_wr_en_i(id_wr_en),
        .id_wr_reg_i(id_wr_reg), .id_halt_i(id_halt), .mem_redirect_i(mem_redirect),
        .pc_stall_o(pc_stall), .id_ex_bubble_o(id_ex_bubble), .flush_if_id_o(flush_if_id),
        .flush_id_ex_o(flush_id_ex), .flush_ex_mem_o(flush_ex_mem), .halted_o(halted),
        .stall_count_o(stall_count)
    );

    typedef struct packed {
        logic        pc_stall, bubble, f_ifid, f_idex, f_exmem, halted;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        logic [2:0] r;
        int         age;   // 1 = EX, 2 = MEM, 3 = WB
    } fl_t;

    out_t exp_q[$];
    fl_t  fl[$];
    int   halt_age;        // 0 = no HALT draining, else pipeline stage of the HALT
    bit   halted_m;
    int   cnt_m;
    int   checks = 0, errors = 0;
    bit   done = 0;

    function automatic bit m_hazard();
        bit hit = 0;
        foreach (fl[i]) begin
            if (id_rs_used && fl[i].r == id_rs) hit = 1;
            if (id_rt_used && fl[i].r == id_rt) hit = 1;
        end
        return id_valid && hit;
    endfunction

    function automatic out_t m_expect();
        out_t o = '0;
        if (!rst_n) begin
            o.f_ifid = 1; o.f_idex = 1; o.f_exmem = 1;
            return o;
        end
        o.halted = halted_m;
        o.cnt    = cnt_m[15:0];
        if (mem_redirect && !halted_m) begin
            o.f_ifid = 1; o.f_idex = 1; o.f_exmem = 1;
        end else if (halted_m || halt_age != 0 || m_hazard()) begin
            o.pc_stall = 1; o.bubble = 1;
        end
        return o;
    endfunction

    task automatic m_reset();
        fl.delete();
        halt_age = 0;
        halted_m = 0;
        cnt_m    = 0;
    endtask

    task automatic m_edge();
        bit   redir = mem_redirect && !halted_m;
        bit   busy  = redir || halted_m || halt_age != 0;
        bit   haz   = m_hazard();
        bit   iss   = !busy && !haz && id_valid;
        fl_t  nq[$];
        if (!busy && haz && cnt_m < 65535) cnt_m++;
        if (halt_age != 0) begin
            if (redir && halt_age == 1) halt_age = 0;
            else if (halt_age == 3) begin halt_age = 0; halted_m = 1; end
            else halt_age++;
        end else if (iss && id_halt) halt_age = 1;
        foreach (fl[i]) begin
            if (!(redir && fl[i].age == 1) && fl[i].age < 3) nq.push_back('{fl[i].r, fl[i].age + 1});
        end
        if (iss && id_wr_en) nq.push_back('{id_wr_reg, 1});
        fl = nq;
    endtask

    task automatic drive(input logic rst, input logic v, input logic [2:0] rs, input logic rsu,
                         input logic [2:0] rt, input logic rtu, input logic we, input logic [2:0] wr,
                         input logic hlt, input logic redir);
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
        rst_n = rst; id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_wr_en = we; id_wr_reg = wr; id_halt = hlt; mem_redirect = redir;
        if (!rst_n) m_reset();
        exp_q.push_back(m_expect());
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1, 3'($urandom_range(0, 7)), 1,
              1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive(0, 1, 3, 1, 4, 1, 1, 5, 0, 1);
        idle();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a fresh output vector every cycle.
    initial begin
        out_t e, a;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{pc_stall, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, halted, stall_count};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got stall=%b bub=%b fl=%b%b%b halted=%b cnt=%0d expected stall=%b bub=%b fl=%b%b%b halted=%b cnt=%0d",
                             $time, a.pc_stall, a.bubble, a.f_ifid, a.f_idex, a.f_exmem, a.halted, a.cnt,
                             e.pc_stall, e.bubble, e.f_ifid, e.f_idex, e.f_exmem, e.halted, e.cnt);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
        id_wr_en = 0; id_wr_reg = 0; id_halt = 0; mem_redirect = 0;
        m_reset();

        // RAW against a producer in EX: three bubbles.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 1, 3, 0, 0);
        repeat (5) drive(1, 1, 3, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ex_producer_stalls", stall_count, 3);

        // Producer already in MEM: two bubbles.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        idle();
        repeat (4) drive(1, 1, 2, 0, 5, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("mem_producer_stalls", stall_count, 2);

        // Independent registers, R0 treated as ordinary.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        drive(1, 1, 2, 1, 3, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("independent_no_stall", pc_stall, 0);
        drive(1, 1, 0, 1, 4, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_hazard_stall", pc_stall, 1);

        // Hazard coinciding with a redirect: flush wins, hazard gone afterwards.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 1, 4, 0, 0);
        drive(1, 1, 4, 1, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("redirect_flush_ex_mem", flush_ex_mem, 1);
        chk("redirect_no_stall", pc_stall, 0);
        drive(1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_redirect_no_hazard", pc_stall, 0);

        // HALT drain: halted rises on the fourth edge after issue.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) idle();
        @(negedge clk);
        chk("halt_not_yet", halted, 0);
        chk("halt_drain_stall", pc_stall, 1);
        idle();
        @(negedge clk);
        chk("halt_raised", halted, 1);
        repeat (4) drive(1, 1, 1, 0, 0, 0, 1, 2, 0, 0);
        @(negedge clk);
        chk("halt_sticky", halted, 1);
        chk("halt_stall_sticky", pc_stall, 1);

        // HALT in EX squashed by an older redirect.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 1, 0, 1, 0, 1, 2, 0, 0);
        @(negedge clk);
        chk("squashed_halt_issue", pc_stall, 0);
        repeat (4) idle();
        @(negedge clk);
        chk("squashed_halt_not_halted", halted, 0);

        // Randomised traffic, including occasional mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        done = 1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
